// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the IF/MEM backing-memory arbiter.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and backing-memory port.
// The slave modport is the arbiter's view; master is the surrounding pipeline and memory.
interface mem_port_arbiter_if
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_ack_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_ack_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter used to count pipeline stall cycles.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count up while asked to, but stick at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register, cleared by the shared reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Optional build macro MEM_ARB_RR_EN: round-robin tie-breaking instead of data-first.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_BUSY_IF = BUSY_IF;
  localparam logic [1:0] ST_BUSY_DM = BUSY_DM;
  localparam logic [1:0] ST_RESP    = RESP;

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              pick_dm;

`ifdef MEM_ARB_RR_EN
  grant_t last_grant_q, last_grant_d;

  // On a tie, the requester that was not served last time goes first.
  always_comb begin
    pick_dm = bus.dm_req_i & (~bus.if_req_i | (last_grant_q == GNT_IF));
  end

  // Remember who won each grant taken from IDLE.
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ST_IDLE) begin
      if (pick_dm) begin
        last_grant_d = GNT_DM;
      end else if (bus.if_req_i) begin
        last_grant_d = GNT_IF;
      end
    end
  end

  // Round-robin history register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= GNT_IF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Data always wins: the load/store belongs to the older instruction.
  always_comb begin
    pick_dm = bus.dm_req_i;
  end
`endif

  // Grant, hold the memory request until it completes, then spend one cycle acking.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_dm) begin
          state_d     = ST_BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we_i;
          mem_addr_d  = bus.dm_addr_i;
          mem_wdata_d = bus.dm_wdata_i;
        end else if (bus.if_req_i) begin
          state_d    = ST_BUSY_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr_i;
        end
      end
      ST_BUSY_IF: begin
        if (bus.mem_ack_i) begin
          state_d    = ST_RESP;
          mem_req_d  = 1'b0;
          if_rdata_d = bus.mem_rdata_i;
          if_ack_d   = 1'b1;
        end
      end
      ST_BUSY_DM: begin
        if (bus.mem_ack_i) begin
          state_d    = ST_RESP;
          mem_req_d  = 1'b0;
          dm_rdata_d = bus.mem_rdata_i;
          dm_ack_d   = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.dm_ack_o    = dm_ack_q;

  // The pipeline freezes while any requester is waiting and not being acked this cycle.
  always_comb begin
    stall_o = (bus.if_req_i & ~if_ack_q) | (bus.dm_req_i & ~dm_ack_q);
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_o),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Sits between the PC/IFID side, the EXMEM/MEMWB side and the unified memory model.
- Serialises requests and converts the memory's variable-latency req/ack handshake into per-requester one-cycle acks.
- Drives a global pipeline stall while any requester is still waiting.

Parameters:
- ADDR_W, 32, address width on all three ports.
- DATA_W, 32, data width on all three ports.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetched instruction; valid while if_ack_o=1.
- if_ack_o  out  1  one-cycle fetch completion pulse.
- dm_req_i  in  1  data request; held with address, write enable and write data stable until dm_ack_o.
- dm_we_i  in  1  1=store, 0=load.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  store data.
- dm_rdata_o  out  DATA_W  load data; valid while dm_ack_o=1.
- dm_ack_o  out  1  one-cycle data completion pulse.
- mem_req_o  out  1  backing-memory request.
- mem_we_o  out  1  backing-memory write enable.
- mem_addr_o  out  ADDR_W  backing-memory address.
- mem_wdata_o  out  DATA_W  backing-memory write data.
- mem_rdata_i  in  DATA_W  backing-memory read data; valid with mem_ack_i.
- mem_ack_i  in  1  backing-memory completion; one cycle.
- stall_o  out  1  freeze PC, IFID, IDEX, EXMEM and MEMWB this cycle.
- stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o=1.

Behaviour:
- Reset (async, rst_i=1):
  - State=IDLE.
  - mem_req_o, mem_we_o, if_ack_o, dm_ack_o = 0.
  - mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o = 0.
  - stall_cnt_o = 0.
  - Any outstanding memory op is abandoned; the memory shares the same reset.
- States: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE:
  - dm_req_i=1 → BUSY_DM, latching dm_we_i, dm_addr_i and dm_wdata_i into the mem_* registers.
  - Otherwise if_req_i=1 → BUSY_IF, latching if_addr_i with mem_we_o=0.
  - Otherwise stay in IDLE.
  - Fixed priority: data beats instruction (older instruction first).
- BUSY_x:
  - mem_req_o=1 (registered) with latched fields held stable.
  - On mem_ack_i=1: capture mem_rdata_i into the matching *_rdata_o, set matching *_ack_o=1 next cycle, go to RESP.
  - On a store, dm_rdata_o = mem_rdata_i, value don't-care.
- RESP:
  - Exactly one ack high for this single cycle; mem_req_o=0.
  - Go to IDLE unconditionally.
  - Requesters drop or renew req at the following edge, so a held req is never re-issued.
- Latency: req seen in IDLE at cycle t → mem_req_o high at t+1. mem_ack_i at cycle a (a≥t+1) → ack_o at a+1 → IDLE at a+2. Minimum 3 cycles per access.
- Both requests pending:
  - DM is served first; IF waits in its held state.
  - IF is granted in the next IDLE if DM has dropped its request.
  - DM cannot starve IF: the pipeline is stalled, so MEM presents a new request only after the stall releases.
- mem_ack_i outside BUSY_x is ignored.
- stall_o (combinational) = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
- *_rdata_o hold their last captured value outside ack cycles.
- stall_cnt_o:
  - Increments on every clock with stall_o=1.
  - Saturates at 2^CNT_W−1, with no wrap.
  - Reset clears it.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - Round-robin priority: a 1-bit last_grant register (reset = IF) decides ties in IDLE.
  - Whichever requester was not granted last wins the tie.
  - last_grant updates on each IDLE→BUSY transition.
- MEM_ARB_RR_EN undefined: fixed data-first priority as above.
- Single-requester behaviour is identical in both builds.

Decomposition:
- Package cpu_mem_pkg:
  - arb_state_t enum {IDLE, BUSY_IF, BUSY_DM, RESP}.
  - grant_t enum {GNT_IF, GNT_DM}.
  - Default ADDR_W/DATA_W localparams.
- Sub-module sat_counter (CNT_W parameter; inputs clk_i, rst_i, inc_i; output cnt_o) for the stall counter.
- The FSM and datapath registers stay in the top module.

Test Plan:
- IF-only fetch: if_req_i=1, if_addr_i=0x00000004, memory acks 1 cycle after mem_req_o with 0x8C010000.
  - mem_addr_o=0x4, mem_we_o=0 at t+1; if_ack_o=1 with if_rdata_o=0x8C010000 at t+3.
  - stall_o=1 for t..t+2, then 0.
- Simultaneous requests: dm_req_i (load, 0x00000010) and if_req_i (0x00000008) in the same cycle, 0-wait memory.
  - DM served first (mem_addr_o=0x10).
  - IF (0x8) is issued only after RESP; exactly one ack per request.
  - With MEM_ARB_RR_EN and last_grant=DM, IF is served first.
- Store with 4-cycle memory latency: dm_we_i=1, addr 0x20, data 0xDEADBEEF.
  - mem_req_o held 4 cycles with stable fields; dm_ack_o is a single pulse; no IF issue meanwhile.
- Held request not re-issued: keep dm_req_i high one extra cycle after dm_ack_o.
  - Exactly one memory transaction; a second starts only if req is still high in IDLE, and it is treated as new.
- Reset mid-BUSY_DM: assert rst_i asynchronously between clock edges.
  - mem_req_o, acks and stall_cnt_o go 0 immediately; state returns to IDLE; a stray mem_ack_i afterwards is ignored.
- Counter saturation, with CNT_W=4 and a continuous stall of 20 cycles:
  - stall_cnt_o reaches 15 and holds at 15.
